trigger_seq: RTL and testbench
==============================

TRIGGER_SEQ -- requirements
Module: trigger_seq

Interface
REQ-001 SHALL have parameter BAW, default 8, bus address width; BAW >= clog2(TSN)+2.
REQ-002 SHALL have parameter BDW, default 32, bus data width; BDW >= SDW and BDW >= TCW.
REQ-003 SHALL have parameter SDW, default 32, sample data width.
REQ-004 SHALL have parameter TSN, default 4, number of trigger stages; power of two, 2..16; SSW = clog2(TSN).
REQ-005 SHALL have parameter TCW, default 16, per-stage hit-count width.
REQ-006 SHALL have ports: clk  in  1  clock; the only clock.
REQ-007 SHALL have ports: rst  in  1  reset; synchronous and active-high.
REQ-008 SHALL have ports: bus_wready out 1; bus_wvalid in 1; bus_waddr in BAW; bus_wdata in BDW (write-only configuration bus).
REQ-009 SHALL have ports: ctl_arm  in  1  arm/re-arm pulse.
REQ-010 SHALL have ports: sts_armed out 1; sts_fired out 1; sts_stage out SSW (current stage index).
REQ-011 SHALL have ports: sti_tready out 1; sti_tvalid in 1; sti_tdata in SDW (input stream).
REQ-012 SHALL have ports: sto_tready in 1; sto_tvalid out 1; sto_tevent out 2; sto_tdata out SDW (output stream).

Function
REQ-013 SHALL hold bus_wready at 1; write occurs when bus_wvalid=1.
REQ-014 SHALL decode stage s = bus_waddr[SSW+1:2] and register r = bus_waddr[1:0]; bus_waddr bits above SSW+1 are ignored.
REQ-015 SHALL store per stage, at the decoded address: r=0 msk[SDW]; r=1 val[SDW]; r=2 cnt[TCW]; r=3 flags (bit0 edge mode, bit1 last stage).
REQ-016 SHALL apply config writes on the next clk edge; a write landing mid-run affects the next evaluated sample.
REQ-017 SHALL compute stage match = ((sti_tdata ^ val) & msk) == 0 for the current stage only.
REQ-018 SHALL, in edge mode, qualify a hit as match & ~prev, where prev is the match of the previous accepted sample; prev clears to 0 on arm and on stage advance.
REQ-019 SHALL, in level mode, qualify a hit as match.
REQ-020 SHALL keep a hit counter that increments on each qualified hit while armed; the stage completes when the hit count reaches max(cnt,1).
REQ-021 SHALL, on stage completion with last=0 and stage < TSN-1, advance the stage by 1, clear the counter, and set sto_tevent[0] on that sample.
REQ-022 SHALL, on completion with last=1 or stage = TSN-1, set sto_tevent[1], enter FIRED (sts_armed=0, sts_fired=1), and stop evaluating.
REQ-023 SHALL implement the states IDLE, ARMED and FIRED with these transitions: IDLE->ARMED on ctl_arm; FIRED->ARMED on ctl_arm; ctl_arm in ARMED restarts at stage 0 with the counter cleared.
REQ-024 SHALL, when ctl_arm and a sample transfer occur in the same cycle, let the arm win: that sample is not evaluated and passes with sto_tevent=0.
REQ-025 SHALL evaluate samples only on a sti transfer (sti_tvalid & sti_tready); stalled cycles change no state.
REQ-026 SHALL drive sti_tready = sto_tready | ~sto_tvalid.
REQ-027 SHALL register sto_tdata/sto_tevent on a sti transfer, giving a latency of exactly 1 cycle.
REQ-028 SHALL set sto_tvalid on a sti transfer, clear it on sto_tready without a new transfer, and keep it and the data stable while stalled.
REQ-029 SHALL output sto_tevent=0 for samples in IDLE or FIRED; data passes unchanged in all states.

Reset
REQ-030 SHALL, on rst, clear within 1 cycle: state=IDLE, stage=0, counter=0, prev=0, sto_tvalid=0, sto_tevent=0, sto_tdata=0, sts_*=0.
REQ-031 SHALL, on rst, clear all config (msk=0, so every stage matches; cnt=0; flags=0).
REQ-032 SHALL, when rst is asserted mid-run, discard any held output sample, and SHALL ignore bus writes and ctl_arm in the reset cycle.

Verification
REQ-033 SHALL verify: stage0 msk=FF val=0x12 last=1, arm, samples 0x11,0x12 -> tevent 0,2 and sts_fired=1.
REQ-034 SHALL verify: stage0 cnt=3 level msk=FF val=0xAA; samples AA,00,AA,AA -> tevent[0] only on 4th sample, sts_stage=1.
REQ-035 SHALL verify: edge mode, samples AA,AA,AA,00,AA, cnt=2 -> completion on 5th sample only.
REQ-036 SHALL verify: sto_tready=0 for 5 cycles with a sample pending -> sti_tready=0, sto_tdata held, no stage change.
REQ-037 SHALL verify: 4 stages, last flags 0, all matching -> tevent 1,1,1,2 on samples 1-4, then 0 after FIRED.
REQ-038 SHALL verify: ctl_arm in the same cycle as a matching sample -> tevent 0, stage 0; rst mid-run -> sto_tvalid=0 next cycle.

Source files
------------

// File: rtl/trigger_seq.sv
// ---------------------------------------------------------------------------
// trigger_seq
//   Multi-stage pattern trigger sitting in a valid/ready sample stream.
//   Each stage compares the incoming sample against a masked value, counts
//   qualified hits (level or rising-edge), and either advances to the next
//   stage or fires. Samples always pass through with one cycle of latency;
//   sto_tevent tags the sample that caused a stage advance (bit0) or the
//   final fire (bit1).
//
// Parameters
//   BAW  bus address width   (>= SSW+2)
//   BDW  bus data width      (>= SDW, >= TCW)
//   SDW  sample data width
//   TSN  number of stages    (power of two, 2..16)
//   TCW  per-stage hit-count width
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   bus_w*                   write-only config bus, always ready
//                            addr[SSW+1:2] = stage, addr[1:0] = register
//                            r0 mask, r1 value, r2 count, r3 flags
//                            (flags bit0 edge mode, bit1 last stage)
//   ctl_arm                  arm / re-arm pulse (restarts at stage 0)
//   sts_armed/fired/stage    trigger status
//   sti_*                    input sample stream
//   sto_*                    output sample stream with event tag
// ---------------------------------------------------------------------------
module trigger_seq #(
  parameter int unsigned BAW = 8,
  parameter int unsigned BDW = 32,
  parameter int unsigned SDW = 32,
  parameter int unsigned TSN = 4,
  parameter int unsigned TCW = 16,
  localparam int unsigned SSW = $clog2(TSN)
) (
  input  logic           clk,
  input  logic           rst,

  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,

  input  logic           ctl_arm,

  output logic           sts_armed,
  output logic           sts_fired,
  output logic [SSW-1:0] sts_stage,

  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SDW-1:0] sti_tdata,

  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic [1:0]     sto_tevent,
  output logic [SDW-1:0] sto_tdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  localparam logic [1:0] EV_NONE    = 2'b00;
  localparam logic [1:0] EV_ADVANCE = 2'b01;
  localparam logic [1:0] EV_FIRE    = 2'b10;

  // Per-stage configuration
  logic [SDW-1:0] cfg_msk  [TSN];
  logic [SDW-1:0] cfg_val  [TSN];
  logic [TCW-1:0] cfg_cnt  [TSN];
  logic           cfg_edge [TSN];
  logic           cfg_last [TSN];

  // Sequencer state
  state_t         state;
  logic [SSW-1:0] stage;
  logic [TCW-1:0] hit_cnt;
  logic           prev_match;

  // Combinational helpers
  logic [SSW-1:0] wr_stage_c;
  logic [1:0]     wr_reg_c;
  logic           xfer_c;
  logic           eval_c;
  logic           match_c;
  logic           hit_c;
  logic [TCW:0]   hit_next_c;
  logic [TCW:0]   target_c;
  logic           done_c;
  logic           final_c;
  logic [1:0]     event_c;

  // Upper address bits are don't-care by design
  logic           unused_addr_bits;
  assign unused_addr_bits = ^bus_waddr;

  assign bus_wready = 1'b1;
  assign sti_tready = sto_tready | ~sto_tvalid;
  assign sts_stage  = stage;

  assign wr_stage_c = bus_waddr[SSW+1:2];
  assign wr_reg_c   = bus_waddr[1:0];

  // Configuration registers; writes become visible on the next sample
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TSN; i++) begin
        cfg_msk[i]  <= '0;
        cfg_val[i]  <= '0;
        cfg_cnt[i]  <= '0;
        cfg_edge[i] <= 1'b0;
        cfg_last[i] <= 1'b0;
      end
    end else if (bus_wvalid) begin
      case (wr_reg_c)
        2'd0: cfg_msk[wr_stage_c] <= bus_wdata[SDW-1:0];
        2'd1: cfg_val[wr_stage_c] <= bus_wdata[SDW-1:0];
        2'd2: cfg_cnt[wr_stage_c] <= bus_wdata[TCW-1:0];
        default: begin
          cfg_edge[wr_stage_c] <= bus_wdata[0];
          cfg_last[wr_stage_c] <= bus_wdata[1];
        end
      endcase
    end
  end

  // Stage evaluation for the sample currently on sti; an arm in the same
  // cycle suppresses evaluation so the restart is clean.
  always_comb begin
    xfer_c     = sti_tvalid & sti_tready;
    eval_c     = xfer_c & ~ctl_arm & (state == ST_ARMED);
    match_c    = ((sti_tdata ^ cfg_val[stage]) & cfg_msk[stage]) == '0;
    hit_c      = cfg_edge[stage] ? (match_c & ~prev_match) : match_c;
    hit_next_c = {1'b0, hit_cnt} + (TCW+1)'(1);
    // A count of zero behaves like one
    target_c   = (cfg_cnt[stage] == '0) ? (TCW+1)'(1) : {1'b0, cfg_cnt[stage]};
    // >= keeps a lowered count mid-run from stranding the stage
    done_c     = hit_c & (hit_next_c >= target_c);
    final_c    = cfg_last[stage] | (stage == SSW'(TSN - 1));
    event_c    = EV_NONE;
    if (eval_c && done_c) begin
      event_c = final_c ? EV_FIRE : EV_ADVANCE;
    end
  end

  // Trigger sequencer: IDLE -> ARMED -> FIRED, re-armable from any state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      stage      <= '0;
      hit_cnt    <= '0;
      prev_match <= 1'b0;
      sts_armed  <= 1'b0;
      sts_fired  <= 1'b0;
    end else if (ctl_arm) begin
      state      <= ST_ARMED;
      stage      <= '0;
      hit_cnt    <= '0;
      prev_match <= 1'b0;
      sts_armed  <= 1'b1;
      sts_fired  <= 1'b0;
    end else begin
      case (state)
        ST_ARMED: begin
          if (eval_c) begin
            prev_match <= match_c;
            if (done_c) begin
              hit_cnt <= '0;
              if (final_c) begin
                state     <= ST_FIRED;
                sts_armed <= 1'b0;
                sts_fired <= 1'b1;
              end else begin
                stage      <= stage + SSW'(1);
                prev_match <= 1'b0;
              end
            end else if (hit_c) begin
              hit_cnt <= hit_next_c[TCW-1:0];
            end
          end
        end
        ST_IDLE, ST_FIRED: begin
          state <= state;
        end
        default: begin
          state     <= ST_IDLE;
          sts_armed <= 1'b0;
          sts_fired <= 1'b0;
        end
      endcase
    end
  end

  // Output register slice: one-cycle latency, holds while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      sto_tvalid <= 1'b0;
      sto_tevent <= EV_NONE;
      sto_tdata  <= '0;
    end else if (xfer_c) begin
      sto_tvalid <= 1'b1;
      sto_tevent <= event_c;
      sto_tdata  <= sti_tdata;
    end else if (sto_tready) begin
      sto_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trigger_seq.sv
// Bench for trigger_seq: directed scenarios plus a randomized run checked
// against a sample-level behavioural model of the trigger.
module tb_trigger_seq;

  localparam int unsigned BAW = 8;
  localparam int unsigned BDW = 32;
  localparam int unsigned SDW = 32;
  localparam int unsigned TSN = 4;
  localparam int unsigned TCW = 16;
  localparam int unsigned SSW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           bus_wready;
  logic           bus_wvalid;
  logic [BAW-1:0] bus_waddr;
  logic [BDW-1:0] bus_wdata;
  logic           ctl_arm;
  logic           sts_armed;
  logic           sts_fired;
  logic [SSW-1:0] sts_stage;
  logic           sti_tready;
  logic           sti_tvalid;
  logic [SDW-1:0] sti_tdata;
  logic           sto_tready;
  logic           sto_tvalid;
  logic [1:0]     sto_tevent;
  logic [SDW-1:0] sto_tdata;

  int n_checks = 0;
  int n_errors = 0;

  trigger_seq #(.BAW(BAW), .BDW(BDW), .SDW(SDW), .TSN(TSN), .TCW(TCW)) dut (
    .clk(clk), .rst(rst),
    .bus_wready(bus_wready), .bus_wvalid(bus_wvalid),
    .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
    .ctl_arm(ctl_arm),
    .sts_armed(sts_armed), .sts_fired(sts_fired), .sts_stage(sts_stage),
    .sti_tready(sti_tready), .sti_tvalid(sti_tvalid), .sti_tdata(sti_tdata),
    .sto_tready(sto_tready), .sto_tvalid(sto_tvalid),
    .sto_tevent(sto_tevent), .sto_tdata(sto_tdata)
  );

  always #5 clk = ~clk;

  // Behavioural model: trigger described sample by sample
  bit [31:0] m_msk [TSN];
  bit [31:0] m_val [TSN];
  int        m_cnt [TSN];
  bit        m_edge[TSN];
  bit        m_last[TSN];
  bit        m_armed, m_fired, m_prev;
  int        m_stage, m_hits;
  bit        m_ovalid;
  bit [1:0]  m_oevent;
  bit [31:0] m_odata;

  task automatic model_step();
    bit xfer, match, hit;
    bit [1:0] ev;
    int s, r;
    if (rst) begin
      for (int i = 0; i < TSN; i++) begin
        m_msk[i] = 0; m_val[i] = 0; m_cnt[i] = 0; m_edge[i] = 0; m_last[i] = 0;
      end
      m_armed = 0; m_fired = 0; m_prev = 0; m_stage = 0; m_hits = 0;
      m_ovalid = 0; m_oevent = 0; m_odata = 0;
      return;
    end
    xfer = sti_tvalid && (sto_tready || !m_ovalid);
    ev = 2'b00;
    if (ctl_arm) begin
      m_armed = 1; m_fired = 0; m_stage = 0; m_hits = 0; m_prev = 0;
    end else if (xfer && m_armed) begin
      match = ((sti_tdata ^ m_val[m_stage]) & m_msk[m_stage]) == 0;
      hit = m_edge[m_stage] ? (match && !m_prev) : match;
      m_prev = match;
      if (hit) begin
        m_hits++;
        if (m_hits >= ((m_cnt[m_stage] == 0) ? 1 : m_cnt[m_stage])) begin
          m_hits = 0;
          if (m_last[m_stage] || m_stage == TSN - 1) begin
            ev = 2'b10; m_armed = 0; m_fired = 1;
          end else begin
            ev = 2'b01; m_stage++; m_prev = 0;
          end
        end
      end
    end
    if (xfer) begin
      m_ovalid = 1; m_odata = sti_tdata; m_oevent = ev;
    end else if (sto_tready) begin
      m_ovalid = 0;
    end
    if (bus_wvalid) begin
      s = int'(bus_waddr >> 2) % TSN;
      r = int'(bus_waddr) % 4;
      case (r)
        0: m_msk[s] = bus_wdata;
        1: m_val[s] = bus_wdata;
        2: m_cnt[s] = int'(bus_wdata[15:0]);
        default: begin m_edge[s] = bus_wdata[0]; m_last[s] = bus_wdata[1]; end
      endcase
    end
  endtask

  // One clock: advance the model with the pre-edge inputs, sample #1 after
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; cycle(); rst = 0;
  endtask

  task automatic wr(input int s, input int r, input logic [31:0] d);
    bus_wvalid = 1; bus_waddr = BAW'((s << 2) | r); bus_wdata = d;
    cycle();
    bus_wvalid = 0;
  endtask

  task automatic arm();
    ctl_arm = 1; cycle(); ctl_arm = 0;
  endtask

  task automatic send(input logic [31:0] d);
    sti_tvalid = 1; sti_tdata = d; sto_tready = 1;
    cycle();
    sti_tvalid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (sto_tvalid !== 1'b0) begin n_errors++; $display("FAIL reset_tvalid got=%0b exp=0", sto_tvalid); end
    n_checks++; if (sto_tevent !== 2'b00) begin n_errors++; $display("FAIL reset_tevent got=%0d exp=0", sto_tevent); end
    n_checks++; if (sto_tdata !== 32'h0) begin n_errors++; $display("FAIL reset_tdata got=%h exp=0", sto_tdata); end
    n_checks++; if ({sts_armed, sts_fired, sts_stage} !== 4'b0) begin n_errors++; $display("FAIL reset_sts got=%b exp=0000", {sts_armed, sts_fired, sts_stage}); end
    n_checks++; if (bus_wready !== 1'b1) begin n_errors++; $display("FAIL reset_wready got=%0b exp=1", bus_wready); end
    n_checks++; if (sti_tready !== 1'b1) begin n_errors++; $display("FAIL reset_tready got=%0b exp=1", sti_tready); end
  endtask

  task automatic test_single_fire();
    do_reset();
    wr(0, 0, 32'hFF); wr(0, 1, 32'h12); wr(0, 3, 32'h2);
    arm();
    n_checks++; if (sts_armed !== 1'b1) begin n_errors++; $display("FAIL fire_armed got=%0b exp=1", sts_armed); end
    send(32'h11);
    n_checks++; if (sto_tevent !== 2'd0 || sto_tdata !== 32'h11 || sto_tvalid !== 1'b1) begin n_errors++; $display("FAIL fire_s1 ev=%0d data=%h v=%0b exp ev=0 data=11 v=1", sto_tevent, sto_tdata, sto_tvalid); end
    send(32'h12);
    n_checks++; if (sto_tevent !== 2'd2) begin n_errors++; $display("FAIL fire_s2 got=%0d exp=2", sto_tevent); end
    n_checks++; if (sts_fired !== 1'b1 || sts_armed !== 1'b0) begin n_errors++; $display("FAIL fire_sts fired=%0b armed=%0b exp 1/0", sts_fired, sts_armed); end
  endtask

  task automatic test_count_level();
    logic [31:0] d [4];
    logic [1:0]  e [4];
    d = '{32'hAA, 32'h00, 32'hAA, 32'hAA};
    e = '{2'd0, 2'd0, 2'd0, 2'd1};
    do_reset();
    wr(0, 0, 32'hFF); wr(0, 1, 32'hAA);
    bus_wvalid = 1; bus_waddr = 8'hF2; bus_wdata = 32'd3; cycle(); bus_wvalid = 0;  // upper addr bits ignored
    arm();
    for (int i = 0; i < 4; i++) begin
      send(d[i]);
      n_checks++; if (sto_tevent !== e[i]) begin n_errors++; $display("FAIL level_s%0d got=%0d exp=%0d", i + 1, sto_tevent, e[i]); end
    end
    n_checks++; if (sts_stage !== 2'd1) begin n_errors++; $display("FAIL level_stage got=%0d exp=1", sts_stage); end
  endtask

  task automatic test_edge();
    logic [31:0] d [5];
    d = '{32'hAA, 32'hAA, 32'hAA, 32'h00, 32'hAA};
    do_reset();
    wr(0, 0, 32'hFF); wr(0, 1, 32'hAA); wr(0, 2, 32'd2); wr(0, 3, 32'h1);
    arm();
    for (int i = 0; i < 5; i++) begin
      send(d[i]);
      n_checks++; if (sto_tevent !== ((i == 4) ? 2'd1 : 2'd0)) begin n_errors++; $display("FAIL edge_s%0d got=%0d exp=%0d", i + 1, sto_tevent, (i == 4) ? 1 : 0); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    wr(0, 0, 32'hFF); wr(0, 1, 32'h55);
    arm();
    sti_tvalid = 1; sti_tdata = 32'h33; sto_tready = 0; cycle();
    n_checks++; if (sto_tvalid !== 1'b1 || sto_tdata !== 32'h33) begin n_errors++; $display("FAIL stall_load v=%0b data=%h exp 1/33", sto_tvalid, sto_tdata); end
    sti_tdata = 32'h55;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (sti_tready !== 1'b0) begin n_errors++; $display("FAIL stall_tready c%0d got=%0b exp=0", i, sti_tready); end
      cycle();
      n_checks++; if (sto_tdata !== 32'h33 || sto_tvalid !== 1'b1 || sts_stage !== 2'd0) begin n_errors++; $display("FAIL stall_hold c%0d data=%h v=%0b st=%0d exp 33/1/0", i, sto_tdata, sto_tvalid, sts_stage); end
    end
    sto_tready = 1; cycle(); sti_tvalid = 0;
    n_checks++; if (sto_tdata !== 32'h55 || sto_tevent !== 2'd1 || sts_stage !== 2'd1) begin n_errors++; $display("FAIL stall_release data=%h ev=%0d st=%0d exp 55/1/1", sto_tdata, sto_tevent, sts_stage); end
  endtask

  task automatic test_four_stage();
    logic [1:0] e [4];
    e = '{2'd1, 2'd1, 2'd1, 2'd2};
    do_reset();
    arm();
    for (int i = 0; i < 4; i++) begin
      send($urandom);
      n_checks++; if (sto_tevent !== e[i]) begin n_errors++; $display("FAIL four_s%0d got=%0d exp=%0d", i + 1, sto_tevent, e[i]); end
      if (i == 2) begin
        n_checks++; if (sts_stage !== 2'd3) begin n_errors++; $display("FAIL four_stage got=%0d exp=3", sts_stage); end
      end
    end
    send(32'h5A5A);
    n_checks++; if (sto_tevent !== 2'd0 || sts_fired !== 1'b1 || sto_tdata !== 32'h5A5A) begin n_errors++; $display("FAIL four_after ev=%0d fired=%0b data=%h exp 0/1/5a5a", sto_tevent, sts_fired, sto_tdata); end
  endtask

  task automatic test_arm_collision();
    do_reset();
    arm();
    ctl_arm = 1; sti_tvalid = 1; sti_tdata = 32'h77; sto_tready = 1; cycle();
    ctl_arm = 0; sti_tvalid = 0;
    n_checks++; if (sto_tevent !== 2'd0 || sts_stage !== 2'd0 || sto_tdata !== 32'h77) begin n_errors++; $display("FAIL collide ev=%0d st=%0d data=%h exp 0/0/77", sto_tevent, sts_stage, sto_tdata); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    arm();
    sti_tvalid = 1; sti_tdata = 32'h99; sto_tready = 0; cycle(); sti_tvalid = 0;
    rst = 1; ctl_arm = 1;
    bus_wvalid = 1; bus_waddr = BAW'(3); bus_wdata = 32'h2;  // last=1 on stage0, must be ignored
    cycle();
    rst = 0; ctl_arm = 0; bus_wvalid = 0;
    n_checks++; if (sto_tvalid !== 1'b0 || sto_tdata !== 32'h0) begin n_errors++; $display("FAIL midrst_out v=%0b data=%h exp 0/0", sto_tvalid, sto_tdata); end
    n_checks++; if (sts_armed !== 1'b0) begin n_errors++; $display("FAIL midrst_arm got=%0b exp=0", sts_armed); end
    arm();
    send(32'h0);
    n_checks++; if (sto_tevent !== 2'd1) begin n_errors++; $display("FAIL midrst_cfg got=%0d exp=1", sto_tevent); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      ctl_arm    = ($urandom_range(0, 19) == 0);
      sti_tvalid = ($urandom_range(0, 3) != 0);
      sti_tdata  = $urandom;
      sto_tready = ($urandom_range(0, 3) != 0);
      bus_wvalid = ($urandom_range(0, 9) == 0);
      bus_waddr  = BAW'($urandom);
      case (bus_waddr[1:0])
        2'd0: bus_wdata = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
        2'd1: bus_wdata = 32'($urandom_range(0, 3));
        2'd2: bus_wdata = 32'($urandom_range(0, 3));
        default: bus_wdata = 32'($urandom_range(0, 3));
      endcase
      cycle();
      n_checks++; if (sto_tvalid !== m_ovalid) begin n_errors++; $display("FAIL rnd_tvalid i=%0d got=%0b exp=%0b", i, sto_tvalid, m_ovalid); end
      n_checks++; if (sto_tdata !== m_odata) begin n_errors++; $display("FAIL rnd_tdata i=%0d got=%h exp=%h", i, sto_tdata, m_odata); end
      n_checks++; if (sto_tevent !== m_oevent) begin n_errors++; $display("FAIL rnd_tevent i=%0d got=%0d exp=%0d", i, sto_tevent, m_oevent); end
      n_checks++; if (sts_armed !== m_armed || sts_fired !== m_fired) begin n_errors++; $display("FAIL rnd_sts i=%0d got=%0b%0b exp=%0b%0b", i, sts_armed, sts_fired, m_armed, m_fired); end
      n_checks++; if (sts_stage !== SSW'(m_stage)) begin n_errors++; $display("FAIL rnd_stage i=%0d got=%0d exp=%0d", i, sts_stage, m_stage); end
      n_checks++; if (sti_tready !== (sto_tready | ~m_ovalid)) begin n_errors++; $display("FAIL rnd_tready i=%0d got=%0b exp=%0b", i, sti_tready, sto_tready | ~m_ovalid); end
    end
    rst = 0; ctl_arm = 0; sti_tvalid = 0; bus_wvalid = 0;
  endtask

  initial begin
    rst = 1; bus_wvalid = 0; bus_waddr = '0; bus_wdata = '0; ctl_arm = 0;
    sti_tvalid = 0; sti_tdata = '0; sto_tready = 1;
    test_reset();
    test_single_fire();
    test_count_level();
    test_edge();
    test_stall();
    test_four_stage();
    test_arm_collision();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
